// File: rtl/clk_bringup_pkg.sv
// Shared types for the clock bring-up sequencer: state encoding, failure
// codes and the measured-count type.
package clk_bringup_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_PLL_WAIT,
        ST_SEL,
        ST_CLK_WAIT,
        ST_MEAS,
        ST_SETTLE,
        ST_CHECK,
        ST_RUN,
        ST_FAIL
    } state_e;

    typedef logic [2:0] fail_code_t;

    localparam fail_code_t FC_NONE      = 3'd0;
    localparam fail_code_t FC_PLL_TMO   = 3'd1;
    localparam fail_code_t FC_CLK_TMO   = 3'd2;
    localparam fail_code_t FC_COUNT     = 3'd3;
    localparam fail_code_t FC_LOCK_LOST = 3'd4;

    typedef logic [23:0] count_t;

    // Shared timer width; wide enough for any lock timeout or window.
    localparam int TMR_W = 32;
    typedef logic [TMR_W-1:0] tmr_t;

endpackage

// File: rtl/clk_bringup_timer.sv
// bringup_timer: loadable down-counter shared by every timed state of the
// bring-up sequencer. It holds at zero, and expired_o flags the zero count.
module bringup_timer
    import clk_bringup_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  tmr_t load_val_i,
    output logic expired_o
);

    tmr_t cnt_q;

    // Load on state entry, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - tmr_t'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/clk_bringup_seq.sv
// clk_bringup_seq: autonomous clock bring-up sequencer (PLL reset and lock,
// ClkWiz select and lock, frequency check, then system reset release).
// Optional feature: define CLK_BRINGUP_RETRY_EN to retry failure codes 1-3
// up to MAX_RETRIES times before settling in FAIL.
module clk_bringup_seq
    import clk_bringup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int MEAS_WINDOW    = 100000,
    parameter int COUNT_MIN      = 95000,
    parameter int COUNT_MAX      = 97000,
    parameter int SETTLE_CYCLES  = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clk_sel,
    output logic        pll_reset_o,
    input  logic        pll_locked_i,
    output logic        clkwiz_sel_o,
    input  logic        clkwiz_locked_i,
    output logic        fmeas_en_o,
    input  logic [23:0] fmeas_count_i,
    output logic        sys_reset_o,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  fail_code,
    output logic [23:0] meas_count
);

`ifdef CLK_BRINGUP_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    // With retries disabled the limit is zero, so the retry path never fires.
    localparam logic [31:0] RETRY_LIMIT = RETRY_EN ? 32'(MAX_RETRIES) : 32'd0;

    state_e     state_q, state_d;
    logic       sel_q, clkwiz_sel_q;
    fail_code_t fail_code_q;
    count_t     meas_q;
    logic [31:0] retry_q;

    logic       tmr_load, tmr_exp;
    tmr_t       tmr_val;
    logic       start_acc, fail_set, meas_sample, can_retry, in_window;
    fail_code_t fail_val;

    bringup_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_exp)
    );

    // retry_q only ever counts up to the limit, so inequality means "left".
    assign can_retry = (retry_q != RETRY_LIMIT);
    assign in_window = (meas_q >= count_t'(COUNT_MIN)) && (meas_q <= count_t'(COUNT_MAX));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, failure routing and timer reload on every state entry.
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        fail_set    = 1'b0;
        fail_val    = FC_NONE;
        meas_sample = 1'b0;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    state_d   = ST_PLL_RST;
                    start_acc = 1'b1;
                end
            end
            ST_PLL_RST:  if (tmr_exp) state_d = ST_PLL_WAIT;
            ST_PLL_WAIT: begin
                if (pll_locked_i) begin
                    state_d = ST_SEL;
                end else if (tmr_exp) begin
                    fail_set = 1'b1;
                    fail_val = FC_PLL_TMO;
                end
            end
            ST_SEL:      state_d = ST_CLK_WAIT;
            ST_CLK_WAIT: begin
                if (clkwiz_locked_i) begin
                    state_d = ST_MEAS;
                end else if (tmr_exp) begin
                    fail_set = 1'b1;
                    fail_val = FC_CLK_TMO;
                end
            end
            ST_MEAS:     if (tmr_exp) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (tmr_exp) begin
                    state_d     = ST_CHECK;
                    meas_sample = 1'b1;
                end
            end
            ST_CHECK: begin
                if (in_window) begin
                    state_d = ST_RUN;
                end else begin
                    fail_set = 1'b1;
                    fail_val = FC_COUNT;
                end
            end
            ST_RUN: begin
                if (!pll_locked_i || !clkwiz_locked_i) begin
                    fail_set = 1'b1;
                    fail_val = FC_LOCK_LOST;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lock loss in RUN is never retried.
        if (fail_set) begin
            if (fail_val != FC_LOCK_LOST && can_retry) begin
                state_d = ST_PLL_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end

        tmr_load = (state_d != state_q);
        case (state_d)
            ST_PLL_RST:               tmr_val = tmr_t'(PLL_RST_CYCLES - 1);
            ST_PLL_WAIT, ST_CLK_WAIT: tmr_val = tmr_t'(LOCK_TIMEOUT - 1);
            ST_MEAS:                  tmr_val = tmr_t'(MEAS_WINDOW - 1);
            ST_SETTLE:                tmr_val = tmr_t'(SETTLE_CYCLES - 1);
            default:                  tmr_val = '0;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        pll_reset_o = 1'b0;
        sys_reset_o = 1'b1;
        fmeas_en_o  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;
        case (state_q)
            ST_IDLE:    pll_reset_o = 1'b1;
            ST_PLL_RST: begin
                pll_reset_o = 1'b1;
                busy        = 1'b1;
            end
            ST_MEAS: begin
                fmeas_en_o = 1'b1;
                busy       = 1'b1;
            end
            ST_PLL_WAIT, ST_SEL, ST_CLK_WAIT, ST_SETTLE, ST_CHECK: busy = 1'b1;
            ST_RUN: begin
                sys_reset_o = 1'b0;
                done        = 1'b1;
            end
            ST_FAIL:    fail = 1'b1;
            default:    pll_reset_o = 1'b1;
        endcase
    end

    // Captured select, ClkWiz select, failure code, retry count and sampled count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= 1'b0;
            clkwiz_sel_q <= 1'b0;
            fail_code_q  <= FC_NONE;
            meas_q       <= '0;
            retry_q      <= '0;
        end else begin
            if (start_acc) begin
                sel_q       <= clk_sel;
                fail_code_q <= FC_NONE;
                retry_q     <= '0;
            end
            if (fail_set) begin
                fail_code_q <= fail_val;
                if (state_d == ST_PLL_RST) begin
                    retry_q <= retry_q + 32'd1;
                end
            end
            if (state_d == ST_SEL && state_q != ST_SEL) begin
                clkwiz_sel_q <= sel_q;
            end
            if (meas_sample) begin
                meas_q <= fmeas_count_i;
            end
        end
    end

    assign clkwiz_sel_o = clkwiz_sel_q;
    assign fail_code    = fail_code_q;
    assign meas_count   = meas_q;

endmodule
